fifo_ctrl: RTL

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller for an external storage array.
// Produces read/write strobes, addresses, occupancy flags and sticky errors.
module fifo_ctrl #(
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [ADDR_SIZE:0]   thr_af,
  input  logic [ADDR_SIZE:0]   thr_ae,
  output logic [ADDR_SIZE-1:0] wr_ptr,
  output logic [ADDR_SIZE-1:0] rd_ptr,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam logic [ADDR_SIZE:0] DEPTH_C =
    {1'b1, {ADDR_SIZE{1'b0}}};

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  // Flags come straight from the registered count.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Reset gates the strobes so nothing reaches storage during reset.
  assign mem_write = push_i & ~full  & reset;
  assign mem_read  = pop_i  & ~empty & reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_i & full);
    unf_d    = unf_q | (pop_i & empty);
    if (mem_write)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (mem_read)
      rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({mem_write, mem_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_ptr        = wr_ptr_q;
  assign rd_ptr        = rd_ptr_q;
  assign count         = count_q;
  assign almost_full   = (count_q >= thr_af);
  assign almost_empty  = (count_q <= thr_ae);
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule
